// File: rtl/memory_access_controller.sv
// Request/ack sequencer that owns MAR/MDR and runs one RAM access per request,
// with a programmable number of extra ACCESS cycles for slow memories.
module memory_access_controller #(
    parameter int n    = 8,
    parameter int m    = 16,
    parameter int WAIT = 0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         req,
    input  logic         we,
    input  logic [n-1:0] addr_in,
    input  logic [m-1:0] data_in,
    output logic         ack,
    output logic         busy,
    output logic [m-1:0] data_out,
    output logic [n-1:0] mem_address,
    output logic         mem_enable,
    output logic         mem_rw,
    inout  wire  [m-1:0] MDR_line
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t       state_q, state_d;
    logic [n-1:0] mar_q, mar_d;
    logic [m-1:0] mdr_q, mdr_d;
    logic         op_q, op_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         drive;

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req) begin
                mar_d   = addr_in;
                op_d    = we;
                if (we) mdr_d = data_in;
                state_d = SETUP;
            end
            SETUP: begin
                cnt_d   = WAIT_CNT;
                state_d = ACCESS;
            end
            ACCESS: begin
                // Reads capture only on the final ACCESS edge; writes repeat harmlessly.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (!op_q) mdr_d = MDR_line;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            op_q    <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode from the state register only, so reset clears them without a clock.
    assign drive       = op_q && (state_q == SETUP || state_q == ACCESS);
    assign busy        = (state_q != IDLE);
    assign ack         = (state_q == DONE);
    assign mem_enable  = (state_q == ACCESS);
    assign mem_rw      = drive;
    assign mem_address = mar_q;
    assign data_out    = mdr_q;
    assign MDR_line    = drive ? mdr_q : {m{1'bz}};

endmodule

// File: tb/tb_memory_access_controller.sv
// Bench for memory_access_controller: two instances (WAIT=0 and WAIT=2), each with a
// behavioural RAM and a weak pull on the data bus; transaction-level scoreboard.
module tb_memory_access_controller;

    localparam int          W0   = 0;
    localparam int          W2   = 2;
    localparam logic [15:0] PULL = 16'hC3C3;

    logic        clk = 1'b0;
    logic        clr = 1'b1;

    logic        req = 1'b0, we = 1'b0;
    logic [7:0]  addr_in = '0;
    logic [15:0] data_in = '0;
    logic        ack, busy, mem_enable, mem_rw;
    logic [15:0] data_out;
    logic [7:0]  mem_address;
    wire  [15:0] mdr_line;

    logic        req2 = 1'b0, we2 = 1'b0;
    logic [7:0]  addr_in2 = '0;
    logic [15:0] data_in2 = '0;
    logic        ack2, busy2, mem_enable2, mem_rw2;
    logic [15:0] data_out2;
    logic [7:0]  mem_address2;
    wire  [15:0] mdr_line2;

    logic [15:0] ram0 [256];
    logic [15:0] ram2 [256];
    logic [15:0] ref_mem [256];
    logic [7:0]  written [$];
    logic [15:0] exp_mdr = '0;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    memory_access_controller #(.n(8), .m(16), .WAIT(W0)) u_dut (
        .clk(clk), .clr(clr), .req(req), .we(we), .addr_in(addr_in), .data_in(data_in),
        .ack(ack), .busy(busy), .data_out(data_out), .mem_address(mem_address),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .MDR_line(mdr_line));

    memory_access_controller #(.n(8), .m(16), .WAIT(W2)) u_dut2 (
        .clk(clk), .clr(clr), .req(req2), .we(we2), .addr_in(addr_in2), .data_in(data_in2),
        .ack(ack2), .busy(busy2), .data_out(data_out2), .mem_address(mem_address2),
        .mem_enable(mem_enable2), .mem_rw(mem_rw2), .MDR_line(mdr_line2));

    // RAM models: drive on enabled reads, commit on enabled write edges.
    assign (weak0, weak1) mdr_line  = PULL;
    assign (weak0, weak1) mdr_line2 = PULL;
    assign mdr_line  = (mem_enable  && !mem_rw)  ? ram0[mem_address]  : 16'bz;
    assign mdr_line2 = (mem_enable2 && !mem_rw2) ? ram2[mem_address2] : 16'bz;
    always @(posedge clk) if (mem_enable  && mem_rw)  ram0[mem_address]  <= mdr_line;
    always @(posedge clk) if (mem_enable2 && mem_rw2) ram2[mem_address2] <= mdr_line2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction on the WAIT=0 instance. Cycle k after the sampling edge:
    // k=1 SETUP, k=2..W0+2 ACCESS, k=W0+3 DONE; preceded by one IDLE cycle.
    task automatic do_op(input bit w, input logic [7:0] a, input logic [15:0] d,
                         input bit hold, input bit intrude);
        logic [15:0] exp_rd, exp_line, exp_out;
        bit          acc;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ack", 32'(ack), 32'd0);
        chk("idle_en", 32'(mem_enable), 32'd0);
        chk("idle_line", 32'(mdr_line), 32'(PULL));
        req = 1'b1; we = w; addr_in = a; data_in = d;
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
        exp_rd = w ? d : ref_mem[a];
        for (int k = 1; k <= W0 + 3; k++) begin
            @(negedge clk);
            acc      = (k >= 2 && k <= W0 + 2);
            exp_line = (w && k <= W0 + 2) ? d : ((!w && acc) ? ref_mem[a] : PULL);
            exp_out  = w ? d : ((k == W0 + 3) ? exp_rd : exp_mdr);
            chk("busy", 32'(busy), 32'd1);
            chk("ack", 32'(ack), 32'(k == W0 + 3));
            chk("mem_enable", 32'(mem_enable), 32'(acc));
            chk("mem_rw", 32'(mem_rw), 32'(w && k <= W0 + 2));
            chk("mem_address", 32'(mem_address), 32'(a));
            chk("line", 32'(mdr_line), 32'(exp_line));
            chk("line_known", 32'($isunknown(mdr_line)), 32'd0);
            chk("data_out", 32'(data_out), 32'(exp_out));
            if (intrude && k == 1) begin
                req = 1'b1; addr_in = 8'h55; we = ~w; data_in = ~d;
            end
            if (intrude && k == 2) req = 1'b0;
        end
        if (w) begin
            chk("ram_commit", 32'(ram0[a]), 32'(d));
            ref_mem[a] = d;
            written.push_back(a);
        end
        exp_mdr = exp_rd;
    endtask

    task automatic op2(input bit w, input logic [7:0] a, input logic [15:0] d,
                       output int ack_at, output int en_cnt);
        @(negedge clk);
        req2 = 1'b1; we2 = w; addr_in2 = a; data_in2 = d;
        @(posedge clk); #1;
        req2 = 1'b0;
        ack_at = 0; en_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (mem_enable2) en_cnt++;
            if (ack2 && ack_at == 0) ack_at = k;
        end
    endtask

    typedef struct {
        bit          w;
        logic [7:0]  a;
        logic [15:0] d;
        bit          hold;
        logic [15:0] exp_out;
    } vec_t;

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t vecs [7];
        int   ack_at, en_cnt;

        vecs[0] = '{1'b1, 8'h3A, 16'hBEEF, 1'b0, 16'hBEEF};
        vecs[1] = '{1'b0, 8'h3A, 16'h0000, 1'b0, 16'hBEEF};
        vecs[2] = '{1'b1, 8'h00, 16'h0001, 1'b1, 16'h0001};
        vecs[3] = '{1'b1, 8'hFF, 16'hFFFE, 1'b1, 16'hFFFE};
        vecs[4] = '{1'b0, 8'h00, 16'h0000, 1'b1, 16'h0001};
        vecs[5] = '{1'b0, 8'hFF, 16'h0000, 1'b0, 16'hFFFE};
        vecs[6] = '{1'b1, 8'h10, 16'h0A0A, 1'b0, 16'h0A0A};

        // Reset state while clr is held.
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_en", 32'(mem_enable), 32'd0);
        chk("rst_rw", 32'(mem_rw), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);
        chk("rst_line", 32'(mdr_line), 32'(PULL));
        @(negedge clk); clr = 1'b0;

        // Asynchronous reset in the middle of a write's ACCESS cycle.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr_in = 8'h77; data_in = 16'h5A5A;
        @(posedge clk); #1 req = 1'b0;
        @(posedge clk); #1;
        chk("pre_clr_en", 32'(mem_enable), 32'd1);
        chk("pre_clr_line", 32'(mdr_line), 32'h5A5A);
        #1 clr = 1'b1;
        #1;
        chk("clr_ack", 32'(ack), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_en", 32'(mem_enable), 32'd0);
        chk("clr_rw", 32'(mem_rw), 32'd0);
        chk("clr_line", 32'(mdr_line), 32'(PULL));
        @(negedge clk); clr = 1'b0;
        @(negedge clk);
        chk("post_clr_busy", 32'(busy), 32'd0);
        chk("post_clr_data_out", 32'(data_out), 32'd0);
        exp_mdr = '0;

        // Directed table, including held-req back-to-back ops at 00/FF.
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].hold, 1'b0);
            chk("tbl_data_out", 32'(data_out), 32'(vecs[i].exp_out));
        end

        // A req pulse during SETUP must be ignored.
        do_op(1'b0, 8'h10, 16'h0000, 1'b0, 1'b1);
        chk("intrude_data_out", 32'(data_out), 32'h0A0A);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("intrude_no_ack", 32'(ack), 32'd0);
            chk("intrude_idle", 32'(busy), 32'd0);
            chk("intrude_addr", 32'(mem_address), 32'h10);
        end

        // WAIT=2: preload via a write, then read back.
        op2(1'b1, 8'h20, 16'h1234, ack_at, en_cnt);
        chk("w2_wr_ack_at", 32'(ack_at), 32'(W2 + 3));
        chk("w2_wr_en_cycles", 32'(en_cnt), 32'(W2 + 1));
        chk("w2_ram", 32'(ram2[8'h20]), 32'h1234);
        op2(1'b0, 8'h20, 16'h0000, ack_at, en_cnt);
        chk("w2_rd_ack_at", 32'(ack_at), 32'(W2 + 3));
        chk("w2_rd_en_cycles", 32'(en_cnt), 32'(W2 + 1));
        chk("w2_data_out", 32'(data_out2), 32'h1234);

        // Random traffic against the scoreboard; reads only hit written words.
        for (int i = 0; i < 60; i++) begin
            bit          w, h;
            logic [7:0]  a;
            logic [15:0] d;
            w = ($urandom_range(0, 1) == 1);
            h = (i != 59) && ($urandom_range(0, 3) == 0);
            d = 16'($urandom);
            if (d == PULL) d = ~d;
            if (w) a = 8'($urandom_range(0, 255));
            else   a = written[$urandom_range(0, written.size() - 1)];
            do_op(w, a, d, h, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
